t07_spi_tft_tx: RTL and testbench

//  Responder/transmit end of the MMIO display-write interface: accepts one displayWrite

---
 rtl/t07_tft_pkg.sv | 43 ++++
 rtl/t07_spi_shift_reg.sv | 34 +++
 rtl/t07_spi_tft_tx.sv | 180 ++++++++++++++++++
 tb/tb_t07_spi_tft_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/t07_tft_pkg.sv
// Shared types, op offsets and decode helpers for the SPI TFT transmitter.
package t07_tft_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        HOLD     = 2'd3
    } tft_state_t;

    localparam int unsigned SHREG_W  = 32;
    localparam int unsigned NBITS_W  = 6;
    localparam int unsigned BITCNT_W = 5;
    localparam int unsigned OP_W     = 4;

    localparam logic [OP_W-1:0] OP_CMD8   = 4'd0;
    localparam logic [OP_W-1:0] OP_DATA8  = 4'd1;
    localparam logic [OP_W-1:0] OP_DATA16 = 4'd2;
    localparam logic [OP_W-1:0] OP_DATA32 = 4'd3;
    localparam logic [OP_W-1:0] OP_RSTCTL = 4'd4;

    // Frame length in bits; zero means the op sends no SPI frame.
    function automatic logic [NBITS_W-1:0] op_nbits(input logic [OP_W-1:0] op);
        case (op)
            OP_CMD8, OP_DATA8: op_nbits = NBITS_W'(8);
            OP_DATA16:         op_nbits = NBITS_W'(16);
            OP_DATA32:         op_nbits = NBITS_W'(32);
            default:           op_nbits = '0;
        endcase
    endfunction

    // Payload left-aligned so the first bit on the wire is always bit 31.
    function automatic logic [SHREG_W-1:0] op_payload(input logic [OP_W-1:0]    op,
                                                      input logic [SHREG_W-1:0] data);
        case (op)
            OP_CMD8, OP_DATA8: op_payload = {data[7:0], 24'h0};
            OP_DATA16:         op_payload = {data[15:0], 16'h0};
            OP_DATA32:         op_payload = data;
            default:           op_payload = '0;
        endcase
    endfunction

endpackage

// File: rtl/t07_spi_shift_reg.sv
// 32-bit left-shift register holding the bits still waiting to go onto MOSI.
module t07_spi_shift_reg
    import t07_tft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [SHREG_W-1:0] data_i,
    output logic               msb_o
);

    logic [SHREG_W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[SHREG_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[SHREG_W-1];

endmodule

// File: rtl/t07_spi_tft_tx.sv
// MMIO display-write responder: serialises one request per displayWrite pulse
// onto a mode-0, MSB-first 4-wire SPI link and holds busy until the frame ends.
module t07_spi_tft_tx
    import t07_tft_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DIV_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        displayWrite,
    input  logic [31:0] displayAddr,
    input  logic [31:0] displayData,
    output logic        busyTFT_o,
    output logic        tft_sclk,
    output logic        tft_mosi,
    output logic        tft_cs_n,
    output logic        tft_dc,
    output logic        tft_rst_n
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    tft_state_t          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [NBITS_W-1:0]  nbits_q, nbits_d;
    logic                armed_q, armed_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                dc_q, dc_d;
    logic                rst_n_q, rst_n_d;

    logic [OP_W-1:0]     op_c;
    logic [NBITS_W-1:0]  op_nbits_c;
    logic [SHREG_W-1:0]  payload_c;
    logic                accept_c;
    logic                div_done_c;
    logic                last_bit_c;
    logic                load_c;
    logic                shift_c;
    logic                sr_msb_c;
    logic                unused_addr_c;

    assign op_c          = displayAddr[OP_W-1:0];
    assign op_nbits_c    = op_nbits(op_c);
    assign payload_c     = op_payload(op_c, displayData);
    assign accept_c      = (state_q == IDLE) && displayWrite && armed_q;
    assign div_done_c    = (div_q == DIV_LAST);
    assign last_bit_c    = (NBITS_W'(bitcnt_q) == (nbits_q - NBITS_W'(1)));
    assign unused_addr_c = ^displayAddr[31:OP_W];

    // Bit 31 goes straight to MOSI on accept; the register keeps the rest.
    t07_spi_shift_reg u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_c),
        .shift_i (shift_c),
        .data_i  ({payload_c[SHREG_W-2:0], 1'b0}),
        .msb_o   (sr_msb_c)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        nbits_d  = nbits_q;
        armed_d  = armed_q;
        busy_d   = busy_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        dc_d     = dc_q;
        rst_n_d  = rst_n_q;
        load_c   = 1'b0;
        shift_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!displayWrite) begin
                    armed_d = 1'b1;
                end
                if (accept_c) begin
                    armed_d = 1'b0;
                    if (op_nbits_c != '0) begin
                        load_c   = 1'b1;
                        state_d  = SHIFT_LO;
                        nbits_d  = op_nbits_c;
                        dc_d     = (op_c != OP_CMD8);
                        cs_n_d   = 1'b0;
                        mosi_d   = payload_c[SHREG_W-1];
                        sclk_d   = 1'b0;
                        busy_d   = 1'b1;
                        div_d    = '0;
                        bitcnt_d = '0;
                    end else if (op_c == OP_RSTCTL) begin
                        rst_n_d = displayData[0];
                    end
                end
            end
            SHIFT_LO: begin
                if (div_done_c) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_done_c) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (last_bit_c) begin
                        state_d = HOLD;
                    end else begin
                        shift_c  = 1'b1;
                        mosi_d   = sr_msb_c;
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        state_d  = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_done_c) begin
                    div_d   = '0;
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bitcnt_q <= '0;
            nbits_q  <= '0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            dc_q     <= 1'b0;
            rst_n_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            nbits_q  <= nbits_d;
            armed_q  <= armed_d;
            busy_q   <= busy_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            dc_q     <= dc_d;
            rst_n_q  <= rst_n_d;
        end
    end

    assign busyTFT_o = busy_q;
    assign tft_sclk  = sclk_q;
    assign tft_mosi  = mosi_q;
    assign tft_cs_n  = cs_n_q;
    assign tft_dc    = dc_q;
    assign tft_rst_n = rst_n_q;

endmodule

// File: tb/tb_t07_spi_tft_tx.sv
// Bench for t07_spi_tft_tx: three instances (CLK_DIV 2/1/3), an SPI frame
// monitor feeding a scoreboard, a vector table and a few hand-written sequences.
module tb_t07_spi_tft_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dw    [3];
    logic [31:0] addr  [3];
    logic [31:0] data  [3];
    logic        busy  [3];
    logic        sclk  [3];
    logic        mosi  [3];
    logic        cs_n  [3];
    logic        dc    [3];
    logic        trst  [3];

    int cdiv [3] = '{2, 1, 3};

    t07_spi_tft_tx #(.CLK_DIV(2), .DIV_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .displayWrite(dw[0]), .displayAddr(addr[0]),
        .displayData(data[0]), .busyTFT_o(busy[0]), .tft_sclk(sclk[0]),
        .tft_mosi(mosi[0]), .tft_cs_n(cs_n[0]), .tft_dc(dc[0]), .tft_rst_n(trst[0]));

    t07_spi_tft_tx #(.CLK_DIV(1), .DIV_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .displayWrite(dw[1]), .displayAddr(addr[1]),
        .displayData(data[1]), .busyTFT_o(busy[1]), .tft_sclk(sclk[1]),
        .tft_mosi(mosi[1]), .tft_cs_n(cs_n[1]), .tft_dc(dc[1]), .tft_rst_n(trst[1]));

    t07_spi_tft_tx #(.CLK_DIV(3), .DIV_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .displayWrite(dw[2]), .displayAddr(addr[2]),
        .displayData(data[2]), .busyTFT_o(busy[2]), .tft_sclk(sclk[2]),
        .tft_mosi(mosi[2]), .tft_cs_n(cs_n[2]), .tft_dc(dc[2]), .tft_rst_n(trst[2]));

    typedef struct {
        int          inst;
        logic        dc;
        int          nbits;
        logic [31:0] bits;
        int          busy;
        int          hp;
        logic        busy_end;
        bit          abort;
    } frame_t;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] data;
        logic        dc;
        int          nbits;
        logic [31:0] bits;
        int          busy;
    } vec_t;

    frame_t exp_q[$];
    frame_t got_q[$];
    int     n_chk  = 0;
    int     n_fail = 0;

    // Monitor state: one frame spans a cs_n fall to the following cs_n rise.
    int          m_starts [3] = '{0, 0, 0};
    int          m_done   [3] = '{0, 0, 0};
    int          m_nb     [3] = '{0, 0, 0};
    int          m_busy   [3] = '{0, 0, 0};
    int          m_run    [3] = '{0, 0, 0};
    int          m_hpmin  [3] = '{0, 0, 0};
    int          m_hpmax  [3] = '{0, 0, 0};
    logic [31:0] m_bits   [3];
    logic        m_dc     [3];
    bit          m_in     [3] = '{0, 0, 0};
    logic        m_pcs    [3] = '{1'b1, 1'b1, 1'b1};
    logic        m_psclk  [3] = '{1'b0, 1'b0, 1'b0};
    frame_t      mg;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_in[i] && m_pcs[i] === 1'b0 && cs_n[i] === 1'b1) begin
                mg.inst     = i;
                mg.dc       = m_dc[i];
                mg.nbits    = m_nb[i];
                mg.bits     = m_bits[i];
                mg.busy     = m_busy[i];
                mg.hp       = (m_hpmin[i] == m_hpmax[i]) ? m_hpmin[i] : -1;
                mg.busy_end = busy[i];
                mg.abort    = 1'b0;
                got_q.push_back(mg);
                m_in[i]   = 1'b0;
                m_done[i] = m_done[i] + 1;
            end else if (m_pcs[i] === 1'b1 && cs_n[i] === 1'b0) begin
                m_in[i]     = 1'b1;
                m_nb[i]     = 0;
                m_bits[i]   = '0;
                m_busy[i]   = 0;
                m_run[i]    = 0;
                m_hpmin[i]  = 1000;
                m_hpmax[i]  = 0;
                m_dc[i]     = dc[i];
                m_starts[i] = m_starts[i] + 1;
            end
            if (m_in[i]) begin
                if (busy[i] === 1'b1) m_busy[i] = m_busy[i] + 1;
                if (sclk[i] === 1'b1 && m_psclk[i] !== 1'b1) begin
                    m_bits[i] = {m_bits[i][30:0], mosi[i]};
                    m_nb[i]   = m_nb[i] + 1;
                end
                if (sclk[i] === 1'b1) begin
                    m_run[i] = m_run[i] + 1;
                end else if (m_psclk[i] === 1'b1) begin
                    if (m_run[i] < m_hpmin[i]) m_hpmin[i] = m_run[i];
                    if (m_run[i] > m_hpmax[i]) m_hpmax[i] = m_run[i];
                    m_run[i] = 0;
                end
            end
            m_pcs[i]   = cs_n[i];
            m_psclk[i] = sclk[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic frame_t mk_exp(input int inst, input logic d, input int nb,
                                      input logic [31:0] b, input int bz, input bit ab);
        frame_t f;
        f.inst     = inst;
        f.dc       = d;
        f.nbits    = nb;
        f.bits     = b;
        f.busy     = bz;
        f.hp       = cdiv[inst];
        f.busy_end = 1'b0;
        f.abort    = ab;
        return f;
    endfunction

    task automatic score();
        frame_t g;
        frame_t e;
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                chk($sformatf("unexpected_frame[%0d]", g.inst), 32'(g.nbits), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("frame_inst", 32'(g.inst), 32'(e.inst));
                chk($sformatf("dc[%0d]", e.inst), 32'(g.dc), 32'(e.dc));
                chk($sformatf("nbits[%0d]", e.inst), 32'(g.nbits), 32'(e.nbits));
                chk($sformatf("bits[%0d]", e.inst), g.bits, e.bits);
                chk($sformatf("busy_at_cs_rise[%0d]", e.inst), 32'(g.busy_end), 32'(e.busy_end));
                if (!e.abort) begin
                    chk($sformatf("busy_cycles[%0d]", e.inst), 32'(g.busy), 32'(e.busy));
                    chk($sformatf("sclk_half_period[%0d]", e.inst), 32'(g.hp), 32'(e.hp));
                end
            end
        end
    endtask

    task automatic wait_done(input int i, input int target);
        for (int c = 0; c < 600 && m_done[i] < target; c++) @(posedge clk);
        chk($sformatf("frame_timeout[%0d]", i), 32'(m_done[i] >= target), 32'(1));
    endtask

    // One displayWrite pulse, preceded by a low cycle; inputs scrambled after accept.
    task automatic send(input int i, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1 dw[i] = 1'b0;
        @(posedge clk); #1 dw[i] = 1'b1; addr[i] = a; data[i] = d;
        @(posedge clk); #1 dw[i] = 1'b0; addr[i] = $urandom; data[i] = $urandom;
    endtask

    vec_t vecs [9];
    int   base;
    int   tgt;

    initial begin
        vecs[0] = '{0, 32'h700, 32'h0000002A, 1'b0, 8,  32'h2A,       34};
        vecs[1] = '{0, 32'h702, 32'h0000F800, 1'b1, 16, 32'hF800,     66};
        vecs[2] = '{0, 32'h701, 32'h123456A5, 1'b1, 8,  32'hA5,       34};
        vecs[3] = '{0, 32'h703, 32'hDEADBEEF, 1'b1, 32, 32'hDEADBEEF, 130};
        vecs[4] = '{0, 32'h010, 32'hFFFFFF81, 1'b0, 8,  32'h81,       34};
        vecs[5] = '{0, 32'h012, 32'hABCD8001, 1'b1, 16, 32'h8001,     66};
        vecs[6] = '{1, 32'h701, 32'h000000A5, 1'b1, 8,  32'hA5,       17};
        vecs[7] = '{2, 32'h701, 32'h000000A5, 1'b1, 8,  32'hA5,       51};
        vecs[8] = '{1, 32'h702, 32'h1234F00F, 1'b1, 16, 32'hF00F,     33};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dw[i] = 1'b0; addr[i] = '0; data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_outputs[%0d]", i),
                32'({busy[i], sclk[i], mosi[i], cs_n[i], dc[i], trst[i]}), 32'(6'b000100));
        rst = 1'b0;

        // Software TFT reset control and an ignored op offset
        base = m_starts[0];
        send(0, 32'h704, 32'h1);
        chk("rstctl_rst_n", 32'(trst[0]), 32'(1));
        repeat (6) @(posedge clk);
        #1;
        chk("rstctl_no_frame", 32'(m_starts[0] - base), 32'(0));
        chk("rstctl_busy", 32'(busy[0]), 32'(0));
        send(0, 32'h709, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_op_outputs", 32'({busy[0], sclk[0], mosi[0], cs_n[0], trst[0]}), 32'(5'b00011));
        chk("ignored_op_no_frame", 32'(m_starts[0] - base), 32'(0));

        for (int v = 0; v < 9; v++) begin
            exp_q.push_back(mk_exp(vecs[v].inst, vecs[v].dc, vecs[v].nbits,
                                   vecs[v].bits, vecs[v].busy, 1'b0));
            tgt = m_done[vecs[v].inst] + 1;
            send(vecs[v].inst, vecs[v].addr, vecs[v].data);
            wait_done(vecs[v].inst, tgt);
            score();
        end

        // Held displayWrite must yield exactly one frame until it drops and rises again
        base = m_starts[0];
        tgt  = m_done[0] + 1;
        exp_q.push_back(mk_exp(0, 1'b1, 8, 32'h3C, 34, 1'b0));
        @(posedge clk); #1 dw[0] = 1'b0;
        @(posedge clk); #1 dw[0] = 1'b1; addr[0] = 32'h701; data[0] = 32'h3C;
        repeat (80) @(posedge clk);
        #1;
        chk("held_single_frame", 32'(m_starts[0] - base), 32'(1));
        wait_done(0, tgt);
        score();
        @(posedge clk); #1 dw[0] = 1'b0;
        @(posedge clk); #1 dw[0] = 1'b1; data[0] = 32'hC3;
        exp_q.push_back(mk_exp(0, 1'b1, 8, 32'hC3, 34, 1'b0));
        wait_done(0, tgt + 1);
        score();
        chk("held_rearm_frame", 32'(m_starts[0] - base), 32'(2));
        dw[0] = 1'b0;

        // Reset after the fifth bit of a DATA32 abandons the frame
        base = m_starts[0];
        tgt  = m_done[0] + 1;
        exp_q.push_back(mk_exp(0, 1'b1, 5, 32'h1B, 0, 1'b1));
        send(0, 32'h703, 32'hDEADBEEF);
        for (int c = 0; c < 50 && m_starts[0] == base; c++) begin @(posedge clk); #1; end
        for (int c = 0; c < 400 && m_nb[0] < 5; c++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outputs", 32'({busy[0], sclk[0], cs_n[0], trst[0]}), 32'(4'b0010));
        dw[0] = 1'b1; addr[0] = 32'h700; data[0] = 32'h55;
        @(posedge clk); #1 rst = 1'b0;
        wait_done(0, tgt);
        score();
        base = m_starts[0];
        repeat (10) @(posedge clk);
        #1;
        chk("rst_with_write_not_accepted", 32'(m_starts[0] - base), 32'(0));
        dw[0] = 1'b0;

        tgt = m_done[0] + 1;
        exp_q.push_back(mk_exp(0, 1'b0, 8, 32'h5A, 34, 1'b0));
        send(0, 32'h700, 32'h5A);
        wait_done(0, tgt);
        score();

        repeat (5) @(posedge clk);
        chk("expected_frames_left", 32'(exp_q.size()), 32'(0));
        chk("unscored_frames_left", 32'(got_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
